// File: rtl/mdu_sched.sv
// Multiply/divide sequencer beside the E-stage ALU: fixed-latency busy window,
// architectural HI/LO ownership and the D-stage stall request.
module mdu_sched #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [31:0]       a_q, b_q;
  logic [1:0]        op_q;

  logic [63:0]       mul_prod;
  logic              a_neg, b_neg, div_zero;
  logic [31:0]       a_mag, b_mag, q_mag, r_mag, div_q, div_r;

  // Results come only from the latched operands; op_q[0] selects unsigned.
  always_comb begin
    if (op_q[0]) begin
      mul_prod = {32'b0, a_q} * {32'b0, b_q};
    end else begin
      mul_prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    end
    a_neg    = ~op_q[0] & a_q[31];
    b_neg    = ~op_q[0] & b_q[31];
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    div_zero = (b_q == 32'd0);
    q_mag    = div_zero ? 32'd0 : a_mag / b_mag;
    r_mag    = div_zero ? 32'd0 : a_mag % b_mag;
    // Magnitude division keeps INT_MIN / -1 at 0x80000000 without overflow.
    div_q    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    div_r    = a_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (op <= 3'd3) begin
              a_q     <= a;
              b_q     <= b;
              op_q    <= op[1:0];
              cnt_q   <= op[1] ? CntW'(DIV_LAT) : CntW'(MUL_LAT);
              state_q <= StBusy;
              busy    <= 1'b1;
            end else if (op == 3'd4) begin
              hi <= a;
            end else if (op == 3'd5) begin
              lo <= a;
            end
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            if (!op_q[1]) begin
              hi <= mul_prod[63:32];
              lo <= mul_prod[31:0];
            end else if (!div_zero) begin
              hi <= div_r;
              lo <= div_q;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall = md_use & (busy | (start & (op <= 3'd3)));

endmodule

// File: tb/tb_mdu_sched.sv
// Randomised bench for mdu_sched: a driver with an arithmetic reference model feeds
// a scoreboard queue; a negedge monitor checks each HI/LO result when it is due.
module tb_mdu_sched;

  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset, start, md_use;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, stall;

  mdu_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .md_use(md_use), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          pe = 0;
  logic        rst_seen = 1'b1;
  logic        busy_prev = 1'b0;
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;

  always @(posedge clk) begin
    pe       <= pe + 1;
    rst_seen <= reset;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference arithmetic in 64-bit integer math.
  task automatic model_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                              output logic [31:0] rh, output logic [31:0] rl);
    longint          sx, sy, p, q, r;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    rh = m_hi;
    rl = m_lo;
    case (o)
      3'd0: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
      3'd2: if (y != 0) begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
      3'd3: if (y != 0) begin rl = x / y; rh = x % y; end
      default: ;
    endcase
  endtask

  // One clock cycle: drive after negedge, check stall, model the edge, return at negedge.
  task automatic step(input logic st, input logic [2:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic mu, input logic rs);
    int pn;
    reset = rs; start = st; op = o; a = x; b = y; md_use = mu;
    #1;
    chk("stall", {31'b0, stall}, {31'b0, mu & ((m_left != 0) | (st & (o <= 3'd3)))});
    pn = pe + 1;
    @(posedge clk);
    if (rs) begin
      m_hi = 0; m_lo = 0; m_left = 0;
      sb.delete();
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (st && o <= 3'd3) begin
      model_result(o, x, y, p_hi, p_lo);
      m_left = (o >= 3'd2) ? int'(DIV_LAT) : int'(MUL_LAT);
      sb.push_back('{p_hi, p_lo, pn + m_left});
    end else if (st && o == 3'd4) begin
      m_hi = x;
      sb.push_back('{m_hi, m_lo, pn});
    end else if (st && o == 3'd5) begin
      m_lo = x;
      sb.push_back('{m_hi, m_lo, pn});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic mu);
    step(1'b0, 3'd7, $urandom, $urandom, mu, 1'b0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic mu);
    step(1'b1, o, x, y, mu, 1'b0);
    while (m_left != 0) idle(mu);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops an expectation when it falls due or when busy drops.
  always @(negedge clk) begin
    if (rst_seen === 1'b0) begin
      if (sb.size() > 0 && (sb[0].due == pe || (busy_prev === 1'b1 && busy === 1'b0))) begin
        mon_e = sb.pop_front();
        chk("latency", 32'(pe), 32'(mon_e.due));
        chk("busy_done", {31'b0, busy}, 32'd0);
        chk("hi", hi, mon_e.hi);
        chk("lo", lo, mon_e.lo);
      end else if (busy_prev === 1'b1 && busy === 1'b0) begin
        chk("spurious_done", {31'b0, busy}, 32'd1);
      end
    end
    busy_prev = busy;
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd7; a = 0; b = 0; md_use = 1'b0;
    @(negedge clk);
    step(1'b0, 3'd7, 0, 0, 1'b0, 1'b1);
    step(1'b0, 3'd7, 0, 0, 1'b1, 1'b1);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);

    step(1'b1, 3'd4, 32'h1234_5678, 0, 1'b1, 1'b0);
    chk("mthi_busy", {31'b0, busy}, 32'd0);

    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    run_op(3'd3, 32'h0000_0007, 32'h0000_0002, 1'b0);
    step(1'b1, 3'd5, 32'hCAFE_BABE, 0, 1'b0, 1'b0);
    run_op(3'd2, 32'h0000_1234, 32'h0000_0000, 1'b0);
    run_op(3'd3, 32'h0000_1234, 32'h0000_0000, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // MTHI issued mid-window must be ignored.
    step(1'b1, 3'd0, 32'h0001_0003, 32'h0000_0007, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b1, 3'd4, 32'h0000_DEAD, 0, 1'b1, 1'b0);
    while (m_left != 0) idle(1'b1);
    idle(1'b1);

    // Reset aborts an in-flight divide; no late write afterwards.
    step(1'b1, 3'd2, 32'd100, 32'd7, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    step(1'b0, 3'd7, 0, 0, 1'b0, 1'b1);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    repeat (12) idle(1'b0);
    chk("late_hi", hi, 32'd0);
    chk("late_lo", lo, 32'd0);

    // Back-to-back: next MULT issued in the first idle cycle.
    step(1'b1, 3'd0, 32'd3, 32'd5, 1'b0, 1'b0);
    repeat (MUL_LAT) idle(1'b0);
    run_op(3'd0, 32'hFFFF_FFF9, 32'd9, 1'b1);

    repeat (2000) begin
      step(($urandom % 3) == 0, 3'($urandom), pick(), pick(), 1'($urandom),
           ($urandom % 256) == 0);
    end
    while (m_left != 0) idle(1'b0);
    idle(1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
